// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD custom instructions (read and write sides).
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EN_HI,
    ST_EN_LO,
    ST_DONE
  } lcd_state_e;

  typedef enum logic [1:0] {
    MODE_BF   = 2'd0,
    MODE_DATA = 2'd1,
    MODE_POLL = 2'd2,
    MODE_RSVD = 2'd3
  } lcd_mode_e;

  // Field positions inside the 32-bit custom-instruction result
  localparam int unsigned BYTE_LSB    = 0;
  localparam int unsigned TIMEOUT_BIT = 8;
  localparam int unsigned COUNT_LSB   = 16;

  // Default bus timing in clk cycles at 50 MHz
  localparam int unsigned LCD_T_AS     = 2;
  localparam int unsigned LCD_T_EH     = 12;
  localparam int unsigned LCD_T_EL     = 14;
  localparam logic [15:0] LCD_POLL_MAX = 16'hFFFF;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable 16-bit down-counter timing one bus phase; expire marks the phase's last cycle.
module lcd_phase_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        expire
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Load takes priority; otherwise count down and rest at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // Counter register, frozen while en is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/lcd_reader.sv
// Read side of the character LCD bus as a multi-cycle Nios custom instruction.
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int unsigned T_AS     = LCD_T_AS,
  parameter int unsigned T_EH     = LCD_T_EH,
  parameter int unsigned T_EL     = LCD_T_EL,
  parameter logic [15:0] POLL_MAX = LCD_POLL_MAX
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] result,
  output logic        busy,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  input  logic [7:0]  lcd_db_in
);

  if (T_AS == 0 || T_EH == 0 || T_EL == 0) begin : g_bad_timing
    $error("lcd_reader: T_AS, T_EH and T_EL must all be non-zero");
  end

  localparam logic [15:0] LOAD_AS = 16'(T_AS - 1);
  localparam logic [15:0] LOAD_EH = 16'(T_EH - 1);
  localparam logic [15:0] LOAD_EL = 16'(T_EL - 1);

  lcd_state_e  state_q, state_d;
  lcd_mode_e   mode_q, mode_d;
  logic        rs_q, rs_d;
  logic [7:0]  byte_q, byte_d;
  logic        timeout_q, timeout_d;
  logic [15:0] count_q, count_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        en_q, en_d;
  logic [7:0]  db_q;

  logic        tmr_load;
  logic [15:0] tmr_val;
  logic        tmr_expire;
  logic        unused_dataa;

  assign unused_dataa = ^dataa[31:2];

  lcd_phase_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (clk_en),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // db pins pass through one input register regardless of clk_en
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_q <= '0;
    end else begin
      db_q <= lcd_db_in;
    end
  end

  // Next-state, capture and phase-timer load decisions
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    rs_d      = rs_q;
    byte_d    = byte_q;
    timeout_d = timeout_q;
    count_d   = count_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && clk_en) begin
          mode_d    = (dataa[1:0] == MODE_RSVD) ? MODE_BF : lcd_mode_e'(dataa[1:0]);
          rs_d      = (dataa[1:0] == MODE_DATA);
          count_d   = '0;
          timeout_d = 1'b0;
          tmr_load  = 1'b1;
          tmr_val   = LOAD_AS;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          tmr_val  = LOAD_EH;
          state_d  = ST_EN_HI;
        end
      end
      ST_EN_HI: begin
        if (tmr_expire) begin
          byte_d   = db_q;
          count_d  = sat_inc16(count_q);
          tmr_load = 1'b1;
          tmr_val  = LOAD_EL;
          state_d  = ST_EN_LO;
        end
      end
      ST_EN_LO: begin
        if (tmr_expire) begin
          // Busy flag still set in poll mode: re-read until it clears or the budget runs out
          if (mode_q == MODE_POLL && byte_q[7]) begin
            if (count_q < POLL_MAX) begin
              tmr_load = 1'b1;
              tmr_val  = LOAD_AS;
              state_d  = ST_SETUP;
            end else begin
              timeout_d = 1'b1;
              state_d   = ST_DONE;
            end
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Pin and handshake outputs are registered from the next state
    done_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_SETUP) || (state_d == ST_EN_HI) || (state_d == ST_EN_LO);
    en_d   = (state_d == ST_EN_HI);
  end

  // State and output registers, all frozen while clk_en is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_BF;
      rs_q      <= 1'b0;
      byte_q    <= '0;
      timeout_q <= 1'b0;
      count_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      en_q      <= 1'b0;
    end else if (clk_en) begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      rs_q      <= rs_d;
      byte_q    <= byte_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      en_q      <= en_d;
    end
  end

  // Assemble the result word from its fields
  always_comb begin
    result                       = '0;
    result[BYTE_LSB +: 8]        = byte_q;
    result[TIMEOUT_BIT]          = timeout_q;
    result[COUNT_LSB +: 16]      = count_q;
  end

  assign done   = done_q;
  assign busy   = busy_q;
  assign lcd_rs = rs_q;
  assign lcd_rw = busy_q;
  assign lcd_en = en_q;

endmodule

// File: tb/tb_lcd_reader.sv
// Self-checking bench for lcd_reader: directed scenarios plus randomized reads against a transaction model.
module tb_lcd_reader;
  import lcd_pkg::*;

  localparam int PERIOD = LCD_T_AS + LCD_T_EH + LCD_T_EL;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic        start5 = 1'b0;
  logic [31:0] dataa = '0;
  logic [7:0]  db = '0;

  logic        done, busy, lcd_rs, lcd_rw, lcd_en;
  logic [31:0] result;
  logic        d5_done, d5_busy, d5_rs, d5_rw, d5_en;
  logic [31:0] d5_result;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  lcd_reader dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start), .dataa(dataa),
    .done(done), .result(result), .busy(busy), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_en(lcd_en), .lcd_db_in(db)
  );

  lcd_reader #(.POLL_MAX(16'd5)) dut5 (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start5), .dataa(dataa),
    .done(d5_done), .result(d5_result), .busy(d5_busy), .lcd_rs(d5_rs), .lcd_rw(d5_rw),
    .lcd_en(d5_en), .lcd_db_in(db)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transaction model: how many reads happen and what word comes back
  function automatic logic [31:0] model(input logic [1:0] mode, input logic [7:0] seq[$],
                                        input int pmax, output int reads);
    logic [7:0] b;
    bit poll;
    poll  = (mode == 2'd2);
    reads = 0;
    do begin
      b = seq[(reads < seq.size()) ? reads : seq.size() - 1];
      reads++;
    end while (poll && b[7] && reads < pmax);
    return {16'(reads), 7'd0, (poll && b[7]), b};
  endfunction

  task automatic run_txn(input string tag, input bit sel5, input logic [1:0] mode,
                         input logic [7:0] seq[$], input int pmax,
                         input int stall_at, input int stall_len, input bit check_window);
    int reads, exp_done, pulses, done_cyc, idx, first_en, last_en, first_rw, frozen;
    int bad_rs, bad_rw;
    logic [31:0] exp_res, res;
    logic d, b, rs, rw, en, prev_en, exp_rs;
    exp_res  = model(mode, seq, pmax, reads);
    exp_done = 1 + reads * PERIOD + stall_len;
    exp_rs   = (mode == 2'd1);
    pulses = 0; done_cyc = -1; idx = 0; first_en = -1; last_en = -1; first_rw = -1;
    frozen = 0; bad_rs = 0; bad_rw = 0; prev_en = 1'b0;
    db    = seq[0];
    dataa = ($urandom() & 32'hFFFF_FFFC) | 32'(mode);
    if (sel5) start5 = 1'b1; else start = 1'b1;
    tick;
    start = 1'b0; start5 = 1'b0;
    for (int c = 1; c <= exp_done + 20; c++) begin
      if (c > 1) tick;
      if (sel5) begin d = d5_done; b = d5_busy; rs = d5_rs; rw = d5_rw; en = d5_en; res = d5_result; end
      else      begin d = done;    b = busy;    rs = lcd_rs; rw = lcd_rw; en = lcd_en; res = result; end
      if (rw && first_rw < 0) first_rw = c;
      if (en && !prev_en) begin
        pulses++;
        if (first_en < 0) first_en = c;
      end
      if (!en && prev_en) begin
        if (last_en < 0) last_en = c - 1;
        idx++;
        if (idx < seq.size()) db = seq[idx];
      end
      prev_en = en;
      if (b && rs !== exp_rs) bad_rs++;
      if (rw !== b || (en && !rw)) bad_rw++;
      if (d) begin
        done_cyc = c;
        break;
      end
      if (c == stall_at) begin
        clk_en = 1'b0;
        frozen = stall_len;
      end else if (frozen > 0) begin
        frozen--;
        if (frozen == 0) clk_en = 1'b1;
      end
      // A start while busy must be ignored
      if (sel5) start5 = (stall_at >= 0 && c == stall_at + stall_len + 2);
      else      start  = (stall_at >= 0 && c == stall_at + stall_len + 2);
    end
    start = 1'b0; start5 = 1'b0; clk_en = 1'b1;
    chk({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
    chk({tag, " en_pulses"}, 32'(pulses), 32'(reads));
    chk({tag, " result"}, res, exp_res);
    chk({tag, " rs_stable"}, 32'(bad_rs), 32'd0);
    chk({tag, " rw_vs_busy_en"}, 32'(bad_rw), 32'd0);
    if (check_window) begin
      chk({tag, " first_rw"}, 32'(first_rw), 32'd1);
      chk({tag, " first_en"}, 32'(first_en), 32'd3);
      chk({tag, " last_en"}, 32'(last_en), 32'(14 + stall_len));
    end
    tick;
    chk({tag, " done_one_cycle"}, 32'(sel5 ? d5_done : done), 32'd0);
    chk({tag, " idle_busy"}, 32'(sel5 ? d5_busy : busy), 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [1:0] m;
    int len, seen_done, seen_busy;

    // Reset state
    tick; tick;
    chk("rst done", 32'(done), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst rs_rw_en", {29'd0, lcd_rs, lcd_rw, lcd_en}, 32'd0);
    chk("rst result", result, 32'd0);
    reset_n = 1'b1;
    tick;

    // Mode 0 timing window
    q = {8'h25};
    run_txn("mode0", 1'b0, 2'd0, q, 65535, -1, 0, 1'b1);
    // Mode 1 data read
    q = {8'hC3};
    run_txn("mode1", 1'b0, 2'd1, q, 65535, -1, 0, 1'b0);
    // Poll until busy flag clears
    q = {8'h80, 8'h80, 8'h80, 8'h07};
    run_txn("poll4", 1'b0, 2'd2, q, 65535, -1, 0, 1'b0);
    // Poll timeout with small budget
    q = {8'h8A};
    run_txn("poll_timeout", 1'b1, 2'd2, q, 5, -1, 0, 1'b0);
    // clk_en stall during the enable pulse
    q = {8'h3C};
    run_txn("stall", 1'b0, 2'd0, q, 65535, 5, 10, 1'b1);

    // Randomized reads on the default instance
    for (int i = 0; i < 6; i++) begin
      m = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 4);
      q = {};
      for (int k = 0; k < len - 1; k++) q.push_back(8'($urandom()) | 8'h80);
      q.push_back((m == 2'd2) ? (8'($urandom()) & 8'h7F) : 8'($urandom()));
      run_txn($sformatf("rand%0d", i), 1'b0, m, q, 65535, -1, 0, 1'b0);
    end
    // Randomized polls on the small-budget instance
    for (int i = 0; i < 3; i++) begin
      len = $urandom_range(1, 7);
      q = {};
      for (int k = 0; k < len - 1; k++) q.push_back(8'($urandom()) | 8'h80);
      q.push_back(8'($urandom()));
      run_txn($sformatf("rpoll%0d", i), 1'b1, 2'd2, q, 5, -1, 0, 1'b0);
    end

    // Asynchronous reset in the middle of the enable pulse
    db = 8'h55;
    dataa = 32'd1;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    chk("midrst en_before", 32'(lcd_en), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst en", 32'(lcd_en), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst rs_rw", {30'd0, lcd_rs, lcd_rw}, 32'd0);
    tick;
    reset_n = 1'b1;
    tick;
    chk("midrst result", result, 32'd0);
    seen_done = 0; seen_busy = 0;
    repeat (40) begin
      tick;
      if (done) seen_done++;
      if (busy) seen_busy++;
    end
    chk("midrst no_done", 32'(seen_done), 32'd0);
    chk("midrst stays_idle", 32'(seen_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
